// File: rtl/trace_drain_pkg.sv
// Shared types and constants for the trace buffer UART drain.
// TRACE_DRAIN_CKSUM_EN adds the checksum state to the FSM encoding.
package trace_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP       = 3'd1,
    ST_LATCH     = 3'd2,
    ST_SEND_SYNC = 3'd3,
    ST_SEND_DATA = 3'd4
`ifdef TRACE_DRAIN_CKSUM_EN
    ,
    ST_SEND_CKSUM = 3'd5
`endif
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic UART_START     = 1'b0;
  localparam logic UART_STOP      = 1'b1;
  localparam int   BITS_PER_FRAME = 10;

endpackage

// File: rtl/trace_uart_tx.sv
// 8N1 UART byte serializer; byte_ready pulses in the last stop-bit cycle so
// a waiting byte follows the stop bit with no idle gap.
module trace_uart_tx
  import trace_drain_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);

  localparam int DW = $clog2(CLK_DIV);

  logic          r_active;
  logic [9:0]    r_frame;
  logic [3:0]    r_bit_cnt;
  logic [DW-1:0] r_div_cnt;

  logic w_bit_end;
  logic w_last_bit;
  logic w_accept;

  assign w_bit_end  = (r_div_cnt == DW'(CLK_DIV - 1));
  assign w_last_bit = (r_bit_cnt == 4'(BITS_PER_FRAME - 1));
  assign byte_ready = !r_active || (w_bit_end && w_last_bit);
  assign w_accept   = byte_valid && byte_ready;

  // Derived from reset-cleared state so the line goes idle the moment reset asserts.
  assign tx = r_active ? r_frame[0] : UART_STOP;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active  <= 1'b0;
      r_frame   <= '1;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else if (w_accept) begin
      r_active  <= 1'b1;
      r_frame   <= {UART_STOP, byte_in, UART_START};
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_div_cnt <= '0;
        if (w_last_bit) begin
          r_active <= 1'b0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_frame   <= {1'b1, r_frame[9:1]};
        end
      end else begin
        r_div_cnt <= r_div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/trace_drain_uart.sv
// Trace buffer drain: pops 32-bit words and sends SYNC + data bytes (MSB byte
// first) over UART 8N1. Define TRACE_DRAIN_CKSUM_EN to append an XOR checksum byte.
module trace_drain_uart
  import trace_drain_pkg::*;
#(
  parameter int         Fpay      = 32,
  parameter int         CLK_DIV   = 868,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         CNTw      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            drain_en,
  input  logic            fifo_empty,
  input  logic [Fpay-1:0] fifo_dout,
  output logic            fifo_rd,
  output logic            uart_tx,
  output logic            busy,
  output logic [CNTw-1:0] words_sent
);

  localparam int NBYTES = Fpay / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e            r_state;
  logic              r_fifo_rd;
  logic [Fpay-1:0]   r_word;
  logic [IDXW-1:0]   r_byte_idx;
  logic [CNTw-1:0]   r_words_sent;

  state_e            w_state_next;
  logic              w_pop;
  logic              w_latch;
  logic              w_idx_inc;
  logic              w_frame_done;
  logic              w_byte_valid;
  logic              w_byte_ready;
  logic [7:0]        w_byte_in;

  function automatic logic [7:0] word_byte(input logic [Fpay-1:0] w, input int k);
    return w[Fpay-1-8*k -: 8];
  endfunction

`ifdef TRACE_DRAIN_CKSUM_EN
  logic [7:0] w_cksum;

  always_comb begin
    w_cksum = '0;
    for (int k = 0; k < NBYTES; k++) w_cksum = w_cksum ^ word_byte(r_word, k);
  end
`endif

  // Each SEND_* state names the byte currently on the line; the next byte is
  // offered during it and taken on the serializer's end-of-stop-bit pulse.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_latch      = 1'b0;
    w_idx_inc    = 1'b0;
    w_frame_done = 1'b0;
    w_byte_valid = 1'b0;
    w_byte_in    = SYNC_BYTE;
    unique case (r_state)
      ST_IDLE: begin
        if (drain_en && !fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_POP;
        end
      end
      ST_POP: w_state_next = ST_LATCH;
      ST_LATCH: begin
        w_latch      = 1'b1;
        w_byte_valid = 1'b1;
        if (w_byte_ready) w_state_next = ST_SEND_SYNC;
      end
      ST_SEND_SYNC: begin
        w_byte_valid = 1'b1;
        w_byte_in    = word_byte(r_word, 0);
        if (w_byte_ready) w_state_next = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        if (int'(r_byte_idx) < NBYTES - 1) begin
          w_byte_valid = 1'b1;
          w_byte_in    = word_byte(r_word, int'(r_byte_idx) + 1);
          w_idx_inc    = w_byte_ready;
        end else begin
`ifdef TRACE_DRAIN_CKSUM_EN
          w_byte_valid = 1'b1;
          w_byte_in    = w_cksum;
          if (w_byte_ready) w_state_next = ST_SEND_CKSUM;
`else
          if (w_byte_ready) begin
            w_frame_done = 1'b1;
            w_state_next = ST_IDLE;
          end
`endif
        end
      end
`ifdef TRACE_DRAIN_CKSUM_EN
      ST_SEND_CKSUM: begin
        if (w_byte_ready) begin
          w_frame_done = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_fifo_rd    <= 1'b0;
      r_word       <= '0;
      r_byte_idx   <= '0;
      r_words_sent <= '0;
    end else begin
      r_state   <= w_state_next;
      r_fifo_rd <= w_pop;
      if (w_latch) begin
        r_word     <= fifo_dout;
        r_byte_idx <= '0;
      end else if (w_idx_inc) begin
        r_byte_idx <= r_byte_idx + IDXW'(1);
      end
      if (w_frame_done) r_words_sent <= r_words_sent + CNTw'(1);
    end
  end

  trace_uart_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (w_byte_in),
    .byte_valid(w_byte_valid),
    .byte_ready(w_byte_ready),
    .tx        (uart_tx)
  );

  assign fifo_rd    = r_fifo_rd;
  assign busy       = (r_state != ST_IDLE);
  assign words_sent = r_words_sent;

endmodule

// File: tb/tb_trace_drain_uart.sv
// Scoreboard bench for trace_drain_uart: a FIFO model feeds the DUT, popped
// words become expected UART bytes, and a line decoder compares them.
module tb_trace_drain_uart;

  localparam int CD     = 4;
  localparam int CNTW   = 3;
  localparam int NB     = 4;
`ifdef TRACE_DRAIN_CKSUM_EN
  localparam int FRAME_CYC = (2 + NB) * 10 * CD;
`else
  localparam int FRAME_CYC = (1 + NB) * 10 * CD;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            drain_en = 1'b0;
  logic            fifo_empty;
  logic [31:0]     fifo_dout = '0;
  logic            fifo_rd;
  logic            uart_tx;
  logic            busy;
  logic [CNTW-1:0] words_sent;

  trace_drain_uart #(
    .Fpay(32), .CLK_DIV(CD), .CNTw(CNTW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .drain_en  (drain_en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd   (fifo_rd),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // ---------------- FIFO model and expected-byte scoreboard ----------------
  logic [31:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  bit          pop_pend = 1'b0;
  logic        prev_rd = 1'b0;
  int          rd_pulses = 0;
  logic [7:0]  exp_q[$];

  assign fifo_empty = (wr_ptr == rd_ptr);

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  function automatic void push_frame(input logic [31:0] w);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < NB; k++) begin
      b = 8'((w >> (8 * (NB - 1 - k))) & 32'hFF);
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef TRACE_DRAIN_CKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  always @(negedge clk) begin
    if (fifo_rd === 1'b1) begin
      check("rd_while_empty", fifo_empty, 0);
      check("rd_one_cycle", prev_rd, 0);
      rd_pulses++;
      if (!fifo_empty) push_frame(mem[rd_ptr % 64]);
    end
    pop_pend = (fifo_rd === 1'b1) && !fifo_empty;
    prev_rd  = fifo_rd;
  end

  always @(posedge clk) begin
    if (pop_pend) begin
      fifo_dout <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // ---------------- UART line monitor ----------------
  int         mon_pos = -1;
  logic [7:0] mon_byte = '0;
  int         last_stop = 0;
  bit         have_stop = 1'b0;
  int         gap_q[$];
  int         tx_low_cnt = 0;
  int         busy_cnt = 0;

  always @(negedge clk) begin
    if (uart_tx !== 1'b1) tx_low_cnt++;
    if (busy !== 1'b0) busy_cnt++;
    if (!reset) begin
      mon_pos   = -1;
      have_stop = 1'b0;
    end else if (mon_pos < 0) begin
      if (uart_tx === 1'b0) begin
        mon_pos = 0;
        if (have_stop && (cyc - last_stop - 1) != 0) gap_q.push_back(cyc - last_stop - 1);
      end
    end else begin
      mon_pos++;
      if (mon_pos == CD / 2) begin
        check("start_bit", uart_tx, 0);
      end else if (mon_pos % CD == CD / 2 && mon_pos < 9 * CD) begin
        mon_byte[mon_pos / CD - 1] = uart_tx;
      end else if (mon_pos == 9 * CD + CD / 2) begin
        check("stop_bit", uart_tx, 1);
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("uart_byte", mon_byte, exp_q.pop_front());
      end
      if (mon_pos == 10 * CD - 1) begin
        last_stop = cyc;
        have_stop = 1'b1;
        mon_pos   = -1;
      end
    end
  end

  // ---------------- bounded wait helpers ----------------
  task automatic wait_busy(input logic val, input int budget, output int at);
    int n = 0;
    while (busy !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_busy", busy, val);
    at = cyc;
  endtask

  task automatic wait_tx(input logic val, input int budget, output int at);
    int n = 0;
    while (uart_tx !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_tx", uart_tx, val);
    at = cyc;
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (!(wr_ptr == rd_ptr && busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", wr_ptr - rd_ptr, 0);
    check("drain_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s, e, rd0, tl0, bc0, exp_words, pushed;
    logic [31:0] w;
    exp_words = 0;

    repeat (3) @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_words", words_sent, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Idle with an empty FIFO: nothing moves.
    rd0 = rd_pulses; tl0 = tx_low_cnt; bc0 = busy_cnt;
    drain_en = 1'b1;
    repeat (1000) @(negedge clk);
    check("idle_rd", rd_pulses - rd0, 0);
    check("idle_tx_low", tx_low_cnt - tl0, 0);
    check("idle_busy", busy_cnt - bc0, 0);

    // Single word: frame length and completion count.
    rd0 = rd_pulses;
    push_word(32'h12345678);
    exp_words++;
    wait_tx(1'b0, 50, s);
    wait_busy(1'b0, FRAME_CYC + 50, e);
    check("frame_len", e - s, FRAME_CYC);
    check("single_words", words_sent, exp_words % (1 << CNTW));
    repeat (5) @(negedge clk);
    check("single_rd", rd_pulses - rd0, 1);
    check("single_bytes_left", exp_q.size(), 0);

    // Back-to-back words: exactly three idle-high cycles between frames.
    gap_q.delete();
    rd0 = rd_pulses;
    push_word(32'hDEADBEEF);
    push_word(32'h00000000);
    push_word(32'hFFFFFFFF);
    exp_words += 3;
    wait_drained(4 * FRAME_CYC);
    check("b2b_rd", rd_pulses - rd0, 3);
    check("b2b_gap_count", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("b2b_gap1", gap_q[1], 3);
      check("b2b_gap2", gap_q[2], 3);
    end
    check("b2b_words", words_sent, exp_words % (1 << CNTW));

    // drain_en drops mid-frame: frame completes, no further pop.
    rd0 = rd_pulses;
    push_word($urandom());
    push_word($urandom());
    wait_tx(1'b0, 50, s);
    repeat (50) @(negedge clk);
    drain_en = 1'b0;
    exp_words++;
    wait_busy(1'b0, FRAME_CYC, e);
    repeat (20) @(negedge clk);
    check("drop_rd", rd_pulses - rd0, 1);
    check("drop_left", wr_ptr - rd_ptr, 1);
    check("drop_words", words_sent, exp_words % (1 << CNTW));
    drain_en = 1'b1;
    exp_words++;
    wait_drained(2 * FRAME_CYC);
    check("drop_flush_words", words_sent, exp_words % (1 << CNTW));

    // Randomized pushes with drain_en pauses; counter wraps past 2^CNTW-1.
    pushed = 0;
    for (int i = 0; i < 5; i++) begin
      w = $urandom();
      push_word(w);
      pushed++;
      if ($urandom_range(0, 1) == 1) begin
        drain_en = 1'b0;
        repeat ($urandom_range(1, 150)) @(negedge clk);
        drain_en = 1'b1;
      end
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    exp_words += pushed;
    wait_drained(8 * FRAME_CYC);
    check("rand_words", words_sent, exp_words % (1 << CNTW));
    check("rand_bytes_left", exp_q.size(), 0);

    // Asynchronous reset 100 cycles into a frame.
    push_word($urandom());
    wait_tx(1'b0, 50, s);
    repeat (100) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_tx", uart_tx, 1);
    check("abort_busy", busy, 0);
    check("abort_fifo_rd", fifo_rd, 0);
    check("abort_words", words_sent, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rd0 = rd_pulses; tl0 = tx_low_cnt; bc0 = busy_cnt;
    repeat (100) @(negedge clk);
    check("post_rst_rd", rd_pulses - rd0, 0);
    check("post_rst_tx_low", tx_low_cnt - tl0, 0);
    check("post_rst_busy", busy_cnt - bc0, 0);
    check("leftover_bytes", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
